// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. One digit is presented per slot; each slot opens
// with an all-anodes-off blanking interval. Display data is double-buffered
// and only swapped at the frame boundary so a frame never tears.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 500,
    parameter int LZS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  load,
    output logic [3:0]            nibble,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick,
    output logic                  busy
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    phase_t                    phase_q, phase_d;
    logic                      boundary;

    logic [DIGITS-1:0][3:0]    pendDig_q, activeDig_q;
    logic [DIGITS-1:0]         pendDp_q, activeDp_q;
    logic [DIGITS-1:0]         pendEn_q, activeEn_q;
    logic                      busy_q;

    logic [DIGITS-1:0]         suppressed;
    logic [DIGITS-1:0]         visible;
    logic                      higherZero;

    logic                      litNow;
    logic [DIGITS-1:0]         anN_d, anN_q;
    logic [3:0]                nibble_q;
    logic                      dpN_d, dpN_q;
    logic                      frameTick_q;

    // Next slot position: cycle counter wraps at DIV-1 and steps the digit index.
    always_comb begin
        boundary = (cnt_q == CW'(DIV - 1)) && (idx_q == IW'(DIGITS - 1));
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        phase_d  = (cnt_d < CW'(BLANK)) ? PH_BLANK : PH_SHOW;
    end

    // Scan FSM: slot counter, digit index and blank/show phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= PH_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    // Double buffer: loads land in pending, pending moves to active at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pendDig_q   <= '0;
            pendDp_q    <= '0;
            pendEn_q    <= '0;
            activeDig_q <= '0;
            activeDp_q  <= '0;
            activeEn_q  <= '0;
            busy_q      <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                activeDig_q <= digits_in;
                activeDp_q  <= dp_in;
                activeEn_q  <= en_in;
            end else if (busy_q) begin
                activeDig_q <= pendDig_q;
                activeDp_q  <= pendDp_q;
                activeEn_q  <= pendEn_q;
            end
            busy_q <= 1'b0;
        end else if (load) begin
            pendDig_q <= digits_in;
            pendDp_q  <= dp_in;
            pendEn_q  <= en_in;
            busy_q    <= 1'b1;
        end
    end

    // Leading-zero suppression scanned from the most significant digit downward.
    always_comb begin
        higherZero = 1'b1;
        suppressed = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if ((LZS != 0) && (k != 0) && (activeDig_q[k] == 4'h0) &&
                !activeDp_q[k] && higherZero) begin
                suppressed[k] = 1'b1;
            end
            if (activeEn_q[k] && (activeDig_q[k] != 4'h0)) begin
                higherZero = 1'b0;
            end
        end
        visible = activeEn_q & ~suppressed;
    end

    // Anode and decimal-point values for the current slot, before registering.
    always_comb begin
        litNow = (phase_q == PH_SHOW) && visible[idx_q];
        anN_d  = '1;
        dpN_d  = 1'b1;
        if (litNow) begin
            anN_d[idx_q] = 1'b0;
            dpN_d        = ~activeDp_q[idx_q];
        end
    end

    // Output registers so every pin changes only on a clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            anN_q       <= '1;
            nibble_q    <= 4'h0;
            dpN_q       <= 1'b1;
            frameTick_q <= 1'b0;
        end else begin
            anN_q       <= anN_d;
            nibble_q    <= activeDig_q[idx_q];
            dpN_q       <= dpN_d;
            frameTick_q <= boundary;
        end
    end

    assign an_n       = anN_q;
    assign nibble     = nibble_q;
    assign dp_n       = dpN_q;
    assign frame_tick = frameTick_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with DIGITS=4, DIV=8,
// BLANK=2. Two instances (leading-zero suppression off and on) share the
// stimulus. A frame-position model predicts every output each cycle, and
// hand-computed literals pin the model at chosen cycles.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk;
    logic        rst;
    logic [15:0] digitsIn;
    logic [3:0]  dpIn;
    logic [3:0]  enIn;
    logic        load;

    logic [3:0]  nibblePlain, nibbleLzs;
    logic        dpNPlain, dpNLzs;
    logic [3:0]  anPlain, anLzs;
    logic        tickPlain, tickLzs;
    logic        busyPlain, busyLzs;

    int vectors     = 0;
    int miscompares = 0;

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .LZS(0)) dutPlain (
        .clk(clk), .rst(rst), .digits_in(digitsIn), .dp_in(dpIn), .en_in(enIn),
        .load(load), .nibble(nibblePlain), .dp_n(dpNPlain), .an_n(anPlain),
        .frame_tick(tickPlain), .busy(busyPlain)
    );

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .LZS(1)) dutLzs (
        .clk(clk), .rst(rst), .digits_in(digitsIn), .dp_in(dpIn), .en_in(enIn),
        .load(load), .nibble(nibbleLzs), .dp_n(dpNLzs), .an_n(anLzs),
        .frame_tick(tickLzs), .busy(busyLzs)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: frame position plus pending/active display contents.
    int         pos;
    logic [3:0] aDig [DIGITS];
    logic       aDp  [DIGITS];
    logic       aEn  [DIGITS];
    logic [3:0] pDig [DIGITS];
    logic       pDp  [DIGITS];
    logic       pEn  [DIGITS];
    logic       mBusy;
    logic       modelValid = 1'b0;
    logic [3:0] expAn [2];
    logic       expDp [2];
    logic [3:0] expNib;
    logic       expTick;
    logic       expBusy;

    // A digit is lit when enabled and not a suppressed leading zero.
    function automatic bit digitLit(int d, int lzs);
        bit allZero;
        if (!aEn[d]) return 1'b0;
        if (lzs != 0 && d != 0 && aDig[d] == 4'h0 && !aDp[d]) begin
            allZero = 1'b1;
            for (int j = d + 1; j < DIGITS; j++) begin
                if (aEn[j] && aDig[j] != 4'h0) allZero = 1'b0;
            end
            if (allZero) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: predicts the outputs that appear after each rising edge.
    initial begin
        int         slotCyc;
        int         d;
        bit         lit;
        logic [3:0] oneHot;
        forever begin
            @(posedge clk);
            if (rst) begin
                pos     = 0;
                mBusy   = 1'b0;
                for (int k = 0; k < DIGITS; k++) begin
                    aDig[k] = 4'h0; aDp[k] = 1'b0; aEn[k] = 1'b0;
                    pDig[k] = 4'h0; pDp[k] = 1'b0; pEn[k] = 1'b0;
                end
                for (int l = 0; l < 2; l++) begin
                    expAn[l] = 4'hF;
                    expDp[l] = 1'b1;
                end
                expNib  = 4'h0;
                expTick = 1'b0;
                expBusy = 1'b0;
            end else begin
                slotCyc = pos % DIV;
                d       = pos / DIV;
                oneHot  = 4'b0001 << d;
                for (int l = 0; l < 2; l++) begin
                    lit      = (slotCyc >= BLANK) && digitLit(d, l);
                    expAn[l] = lit ? ~oneHot : 4'hF;
                    expDp[l] = lit ? ~aDp[d] : 1'b1;
                end
                expNib  = aDig[d];
                expTick = (pos == FRAME - 1);
                if (pos == FRAME - 1) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (load) begin
                            aDig[k] = digitsIn[4*k +: 4]; aDp[k] = dpIn[k]; aEn[k] = enIn[k];
                        end else if (mBusy) begin
                            aDig[k] = pDig[k]; aDp[k] = pDp[k]; aEn[k] = pEn[k];
                        end
                    end
                    mBusy = 1'b0;
                end else if (load) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        pDig[k] = digitsIn[4*k +: 4]; pDp[k] = dpIn[k]; pEn[k] = enIn[k];
                    end
                    mBusy = 1'b1;
                end
                expBusy = mBusy;
                pos     = (pos + 1) % FRAME;
            end
            modelValid = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (modelValid) begin
                checkOutput("an_n lzs0",   32'(anPlain),     32'(expAn[0]));
                checkOutput("an_n lzs1",   32'(anLzs),       32'(expAn[1]));
                checkOutput("dp_n lzs0",   32'(dpNPlain),    32'(expDp[0]));
                checkOutput("dp_n lzs1",   32'(dpNLzs),      32'(expDp[1]));
                checkOutput("nibble lzs0", 32'(nibblePlain), 32'(expNib));
                checkOutput("nibble lzs1", 32'(nibbleLzs),   32'(expNib));
                checkOutput("tick lzs0",   32'(tickPlain),   32'(expTick));
                checkOutput("tick lzs1",   32'(tickLzs),     32'(expTick));
                checkOutput("busy lzs0",   32'(busyPlain),   32'(expBusy));
                checkOutput("busy lzs1",   32'(busyLzs),     32'(expBusy));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle load starting in the current cycle.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        digitsIn = d;
        dpIn     = dp;
        enIn     = en;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Advance to the cycle where frame_tick is high, with a bounded wait.
    task automatic waitFrame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tickPlain !== 1'b1 && n < 2 * FRAME);
        if (tickPlain !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_tick wait: got no pulse, want one within %0d cycles", 2 * FRAME);
        end
    endtask

    // Directed scenarios with literal expectations at known frame offsets.
    initial begin
        int n;
        rst      = 1'b1;
        load     = 1'b0;
        digitsIn = 16'h0;
        dpIn     = 4'h0;
        enIn     = 4'h0;

        $display("[TB] reset");
        tick(3);
        rst = 1'b0;
        checkOutput("reset an_n",   32'(anPlain),     32'hF);
        checkOutput("reset dp_n",   32'(dpNPlain),    32'h1);
        checkOutput("reset nibble", 32'(nibblePlain), 32'h0);
        checkOutput("reset busy",   32'(busyPlain),   32'h0);
        checkOutput("reset tick",   32'(tickPlain),   32'h0);
        waitFrame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tickPlain !== 1'b1 && n < 2 * FRAME);
        checkOutput("frame period", 32'(n), 32'd32);
        checkOutput("dark an_n", 32'(anLzs), 32'hF);

        $display("[TB] basic scan");
        tick(5);
        applyStimulus(16'h1234, 4'b0010, 4'b1111);
        checkOutput("busy after load", 32'(busyPlain), 32'h1);
        waitFrame();
        checkOutput("busy after commit", 32'(busyPlain), 32'h0);
        tick(1);
        checkOutput("slot0 blank an_n",   32'(anPlain),     32'hF);
        checkOutput("slot0 blank nibble", 32'(nibblePlain), 32'h4);
        tick(2);
        checkOutput("slot0 an_n",   32'(anPlain),     32'hE);
        checkOutput("slot0 nibble", 32'(nibblePlain), 32'h4);
        checkOutput("slot0 dp_n",   32'(dpNPlain),    32'h1);
        checkOutput("slot0 an_n lzs", 32'(anLzs),     32'hE);
        tick(6);
        checkOutput("slot1 blank an_n", 32'(anPlain),  32'hF);
        checkOutput("slot1 blank dp_n", 32'(dpNPlain), 32'h1);
        tick(2);
        checkOutput("slot1 an_n",   32'(anPlain),     32'hD);
        checkOutput("slot1 nibble", 32'(nibblePlain), 32'h3);
        checkOutput("slot1 dp_n",   32'(dpNPlain),    32'h0);
        tick(16);
        checkOutput("slot3 an_n",   32'(anPlain),     32'h7);
        checkOutput("slot3 nibble", 32'(nibblePlain), 32'h1);

        $display("[TB] leading zeros");
        tick(2);
        applyStimulus(16'h0050, 4'b0000, 4'b1111);
        waitFrame();
        tick(3);
        checkOutput("lz slot0 lzs1", 32'(anLzs),     32'hE);
        checkOutput("lz slot0 lzs0", 32'(anPlain),   32'hE);
        checkOutput("lz slot0 nib",  32'(nibbleLzs), 32'h0);
        tick(8);
        checkOutput("lz slot1 lzs1", 32'(anLzs),     32'hD);
        checkOutput("lz slot1 nib",  32'(nibbleLzs), 32'h5);
        tick(8);
        checkOutput("lz slot2 lzs1", 32'(anLzs),   32'hF);
        checkOutput("lz slot2 lzs0", 32'(anPlain), 32'hB);
        tick(8);
        checkOutput("lz slot3 lzs1", 32'(anLzs),   32'hF);
        checkOutput("lz slot3 lzs0", 32'(anPlain), 32'h7);

        $display("[TB] no tearing");
        waitFrame();
        tick(10);
        applyStimulus(16'hAAAA, 4'b0000, 4'b1111);
        checkOutput("tear busy A", 32'(busyPlain), 32'h1);
        tick(9);
        applyStimulus(16'h9876, 4'b1000, 4'b1111);
        checkOutput("tear busy B", 32'(busyPlain), 32'h1);
        tick(6);
        checkOutput("tear old an_n",   32'(anPlain),     32'h7);
        checkOutput("tear old nibble", 32'(nibblePlain), 32'h0);
        waitFrame();
        checkOutput("tear busy clear", 32'(busyPlain), 32'h0);
        tick(3);
        checkOutput("tear B slot0 nibble", 32'(nibblePlain), 32'h6);
        tick(24);
        checkOutput("tear B slot3 an_n",   32'(anPlain),     32'h7);
        checkOutput("tear B slot3 nibble", 32'(nibblePlain), 32'h9);
        checkOutput("tear B slot3 dp_n",   32'(dpNPlain),    32'h0);

        $display("[TB] load on boundary");
        waitFrame();
        tick(31);
        applyStimulus(16'hC0DE, 4'b0001, 4'b1111);
        checkOutput("bnd tick", 32'(tickPlain), 32'h1);
        checkOutput("bnd busy", 32'(busyPlain), 32'h0);
        tick(3);
        checkOutput("bnd slot0 an_n",   32'(anPlain),     32'hE);
        checkOutput("bnd slot0 nibble", 32'(nibblePlain), 32'hE);
        checkOutput("bnd slot0 dp_n",   32'(dpNPlain),    32'h0);
        checkOutput("bnd slot0 busy",   32'(busyPlain),   32'h0);

        $display("[TB] mid-slot reset");
        applyStimulus(16'h1111, 4'b0000, 4'b1111);
        checkOutput("pend busy", 32'(busyPlain), 32'h1);
        tick(15);
        checkOutput("pre-rst slot2 lzs0", 32'(anPlain), 32'hB);
        checkOutput("pre-rst slot2 lzs1", 32'(anLzs),   32'hB);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("rst an_n",   32'(anPlain),     32'hF);
        checkOutput("rst busy",   32'(busyPlain),   32'h0);
        checkOutput("rst nibble", 32'(nibblePlain), 32'h0);
        tick(40);
        checkOutput("post-rst dark lzs0", 32'(anPlain),   32'hF);
        checkOutput("post-rst dark lzs1", 32'(anLzs),     32'hF);
        checkOutput("post-rst busy",      32'(busyPlain), 32'h0);
        applyStimulus(16'h0007, 4'b0000, 4'b0001);
        waitFrame();
        tick(3);
        checkOutput("relit slot0 an_n",   32'(anPlain),     32'hE);
        checkOutput("relit slot0 nibble", 32'(nibblePlain), 32'h7);
        tick(8);
        checkOutput("relit slot1 an_n", 32'(anPlain), 32'hF);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
